rf_preload_seq: RTL and testbench

- Parametrised register-file preload sequencer for the single-cycle MIPS top.
- Holds a programmable table of (register address, value) pairs and writes them into the general register file through its normal write port, one entry per clock.
- Holds the CPU in reset while loading and releases it when loading finishes.
- Replaces ad-hoc initialisation of gr[] with synthesizable, multi-entry, restartable preload.

---
 rtl/rf_preload_seq.sv | 185 ++++++++++++++++++
 tb/tb_rf_preload_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_preload_seq.sv
// Register-file preload sequencer: walks a programmable (addr, data, valid) table
// and writes one entry per clock into the register file while holding the CPU.
module rf_preload_seq #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int N_ENTRIES  = 4,
  parameter int IDX_W      = 2,
  parameter int AUTO_START = 1
) (
  input  logic              clk,
  input  logic              r_st,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  input  logic              start,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    wr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W:0]   N_ENT    = (IDX_W+1)'(N_ENTRIES);
  localparam logic [IDX_W:0]   ONE_CNT  = (IDX_W+1)'(1);

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic                auto_pend_r;

  logic [N_ENTRIES-1:0] tbl_valid_r;
  logic [ADDR_W-1:0]    tbl_addr_r [N_ENTRIES];
  logic [DATA_W-1:0]    tbl_data_r [N_ENTRIES];

  logic                cfg_ok_s;
  logic                entry_go_s;
  logic                rf_we_s;
  logic [ADDR_W-1:0]   rf_waddr_s;
  logic [DATA_W-1:0]   rf_wdata_s;
  logic                cpu_hold_s;
  logic                busy_s;
  logic                done_s;
  logic [IDX_W:0]      wr_count_s;

  // Table is frozen during a load; out-of-range indices are dropped.
  always_comb begin
    cfg_ok_s = 1'b0;
    if (cfg_we && (state_r != LOAD) && ({1'b0, cfg_idx} < N_ENT)) begin
      cfg_ok_s = 1'b1;
    end else begin
      cfg_ok_s = 1'b0;
    end
  end

  // r0 is hardwired zero, so an entry targeting it only burns its cycle.
  always_comb begin
    entry_go_s = tbl_valid_r[idx_r] && (tbl_addr_r[idx_r] != {ADDR_W{1'b0}});
  end

  // Table valid bits, cleared by reset so a post-reset load is empty.
  always_ff @(posedge clk or posedge r_st) begin
    if (r_st) begin
      tbl_valid_r <= {N_ENTRIES{1'b0}};
    end else if (cfg_ok_s) begin
      tbl_valid_r[cfg_idx] <= cfg_valid;
    end
  end

  // Table address/data storage; contents only matter once the valid bit is set.
  always_ff @(posedge clk) begin
    if (cfg_ok_s) begin
      tbl_addr_r[cfg_idx] <= cfg_addr;
      tbl_data_r[cfg_idx] <= cfg_data;
    end
  end

  // Next-state and next-output logic for the IDLE/LOAD/FIN sequencer.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    rf_we_s    = 1'b0;
    rf_waddr_s = {ADDR_W{1'b0}};
    rf_wdata_s = {DATA_W{1'b0}};
    cpu_hold_s = 1'b1;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    wr_count_s = wr_count;
    case (state_r)
      IDLE: begin
        if (start || auto_pend_r) begin
          state_s    = LOAD;
          idx_s      = {IDX_W{1'b0}};
          wr_count_s = {(IDX_W+1){1'b0}};
          busy_s     = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        busy_s = 1'b1;
        if (entry_go_s) begin
          rf_we_s    = 1'b1;
          rf_waddr_s = tbl_addr_r[idx_r];
          rf_wdata_s = tbl_data_r[idx_r];
          if (wr_count != N_ENT) begin
            wr_count_s = wr_count + ONE_CNT;
          end else begin
            wr_count_s = wr_count;
          end
        end else begin
          wr_count_s = wr_count;
        end
        if (idx_r == LAST_IDX) begin
          state_s = FIN;
          idx_s   = {IDX_W{1'b0}};
        end else begin
          idx_s = idx_r + ONE_IDX;
        end
      end
      FIN: begin
        cpu_hold_s = 1'b0;
        done_s     = 1'b1;
        // done/cpu_hold keep their FIN values until entry 0 is issued.
        if (start) begin
          state_s    = LOAD;
          idx_s      = {IDX_W{1'b0}};
          wr_count_s = {(IDX_W+1){1'b0}};
          busy_s     = 1'b1;
        end else begin
          state_s = FIN;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, index and the one-shot auto-start flag.
  always_ff @(posedge clk or posedge r_st) begin
    if (r_st) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      auto_pend_r <= (AUTO_START != 0);
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      auto_pend_r <= 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge r_st) begin
    if (r_st) begin
      rf_we    <= 1'b0;
      rf_waddr <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= {(IDX_W+1){1'b0}};
    end else begin
      rf_we    <= rf_we_s;
      rf_waddr <= rf_waddr_s;
      rf_wdata <= rf_wdata_s;
      cpu_hold <= cpu_hold_s;
      busy     <= busy_s;
      done     <= done_s;
      wr_count <= wr_count_s;
    end
  end

endmodule

// File: tb/tb_rf_preload_seq.sv
// Bench for rf_preload_seq: directed scenarios plus randomized tables checked
// against a table/register-file reference model.
module tb_rf_preload_seq;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int N      = 4;
  localparam int IDX_W  = 2;

  logic              clk = 1'b0;
  logic              r_st, r_st_b;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              start, start_b;

  logic              rf_we, cpu_hold, busy, done;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [IDX_W:0]    wr_count;

  logic              b_rf_we, b_cpu_hold, b_busy, b_done;
  logic [ADDR_W-1:0] b_rf_waddr;
  logic [DATA_W-1:0] b_rf_wdata;
  logic [IDX_W:0]    b_wr_count;

  always #5 clk = ~clk;

  rf_preload_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_ENTRIES(N), .IDX_W(IDX_W), .AUTO_START(0)) dut (
    .clk(clk), .r_st(r_st), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .start(start), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .wr_count(wr_count)
  );

  rf_preload_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_ENTRIES(N), .IDX_W(IDX_W), .AUTO_START(1)) dut_auto (
    .clk(clk), .r_st(r_st_b), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .start(start_b), .rf_we(b_rf_we),
    .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata), .cpu_hold(b_cpu_hold), .busy(b_busy),
    .done(b_done), .wr_count(b_wr_count)
  );

  // Reference model: the preload table and the register file it should produce.
  bit                m_valid [N];
  logic [ADDR_W-1:0] m_addr  [N];
  logic [DATA_W-1:0] m_data  [N];
  logic [DATA_W-1:0] gr_exp  [32];
  logic [DATA_W-1:0] gr_obs  [32];
  bit                was_fin;
  int                n_tests;
  int                n_fail;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are observed on the falling edge and writes mirrored.
  task automatic step();
    @(negedge clk);
    if (rf_we === 1'b1) gr_obs[rf_waddr] = rf_wdata;
  endtask

  task automatic cfg_write(input int idx, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit v);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_addr = a; cfg_data = d; cfg_valid = v;
    step();
    cfg_we = 1'b0;
    m_valid[idx] = v; m_addr[idx] = a; m_data[idx] = d;
  endtask

  task automatic run_load(input bit with_cfg, input int c_idx, input logic [ADDR_W-1:0] c_a,
                          input logic [DATA_W-1:0] c_d, input bit c_v, input bit poke);
    int  n_exp;
    bit  exp_we;
    start = 1'b1;
    if (with_cfg) begin
      cfg_we = 1'b1; cfg_idx = IDX_W'(c_idx); cfg_addr = c_a; cfg_data = c_d; cfg_valid = c_v;
      m_valid[c_idx] = c_v; m_addr[c_idx] = c_a; m_data[c_idx] = c_d;
    end
    step();
    start = 1'b0; cfg_we = 1'b0;
    check_eq("enter_busy", busy, 1'b1);
    check_eq("enter_wr_count", wr_count, 0);
    check_eq("enter_done", done, was_fin);
    check_eq("enter_cpu_hold", cpu_hold, !was_fin);
    check_eq("enter_rf_we", rf_we, 1'b0);
    n_exp = 0;
    for (int k = 0; k < N; k++) begin
      if (poke && k == 1) begin
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd2;
        cfg_addr = 5'd9; cfg_data = 32'hBAD0_BAD0; cfg_valid = 1'b1;
      end
      step();
      start = 1'b0; cfg_we = 1'b0;
      exp_we = m_valid[k] && (m_addr[k] != 0);
      check_eq("load_rf_we", rf_we, exp_we);
      if (exp_we) begin
        n_exp++;
        check_eq("load_waddr", rf_waddr, m_addr[k]);
        check_eq("load_wdata", rf_wdata, m_data[k]);
        gr_exp[m_addr[k]] = m_data[k];
      end
      check_eq("load_busy", busy, 1'b1);
      check_eq("load_done", done, 1'b0);
      check_eq("load_cpu_hold", cpu_hold, 1'b1);
      check_eq("load_wr_count", wr_count, n_exp);
    end
    step();
    check_eq("fin_rf_we", rf_we, 1'b0);
    check_eq("fin_busy", busy, 1'b0);
    check_eq("fin_done", done, 1'b1);
    check_eq("fin_cpu_hold", cpu_hold, 1'b0);
    check_eq("fin_wr_count", wr_count, n_exp);
    for (int r = 0; r < 32; r++) check_eq($sformatf("gr[%0d]", r), gr_obs[r], gr_exp[r]);
    was_fin = 1'b1;
  endtask

  // Auto-started load right after releasing the second instance's reset: table is empty.
  task automatic auto_empty_load();
    step();
    check_eq("auto_enter_busy", b_busy, 1'b1);
    for (int k = 0; k < N; k++) begin
      step();
      check_eq("auto_rf_we", b_rf_we, 1'b0);
      check_eq("auto_busy", b_busy, 1'b1);
      check_eq("auto_cpu_hold", b_cpu_hold, 1'b1);
    end
    step();
    check_eq("auto_done", b_done, 1'b1);
    check_eq("auto_cpu_hold_rel", b_cpu_hold, 1'b0);
    check_eq("auto_busy_end", b_busy, 1'b0);
    check_eq("auto_wr_count", b_wr_count, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; was_fin = 1'b0;
    r_st = 1'b0; r_st_b = 1'b0; start = 1'b0; start_b = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_valid = 1'b0;
    for (int i = 0; i < N; i++) begin m_valid[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; end
    for (int r = 0; r < 32; r++) begin gr_exp[r] = '0; gr_obs[r] = '0; end
    #1 r_st = 1'b1; r_st_b = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_rf_we", rf_we, 1'b0);
    check_eq("rst_waddr", rf_waddr, 0);
    check_eq("rst_wdata", rf_wdata, 0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_wr_count", wr_count, 0);
    check_eq("rst_cpu_hold", cpu_hold, 1'b1);
    r_st = 1'b0;
    // Without AUTO_START the sequencer must sit in IDLE.
    repeat (3) begin
      step();
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_cpu_hold", cpu_hold, 1'b1);
      check_eq("idle_rf_we", rf_we, 1'b0);
    end

    // Basic two-entry load.
    cfg_write(0, 5'd1, 32'd1, 1'b1);
    cfg_write(1, 5'd2, 32'd2, 1'b1);
    run_load(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check_eq("basic_gr1", gr_obs[1], 32'd1);
    check_eq("basic_gr2", gr_obs[2], 32'd2);

    // Skips: r0 target and invalid entry.
    cfg_write(0, 5'd0, 32'hDEAD, 1'b1);
    cfg_write(1, 5'd2, 32'd2, 1'b0);
    cfg_write(2, 5'd5, 32'd7, 1'b0);
    cfg_write(3, 5'd3, 32'hFFFF_FFFF, 1'b1);
    run_load(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check_eq("skip_wr_count", wr_count, 1);
    check_eq("skip_gr3", gr_obs[3], 32'hFFFF_FFFF);
    check_eq("skip_gr0", gr_obs[0], 32'd0);

    // Duplicate address: higher index wins.
    cfg_write(0, 5'd0, 32'd0, 1'b0);
    cfg_write(1, 5'd4, 32'h10, 1'b1);
    cfg_write(3, 5'd4, 32'h20, 1'b1);
    run_load(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check_eq("dup_gr4", gr_obs[4], 32'h20);

    // Frozen table and ignored start during LOAD, then rerun on the unchanged table.
    run_load(1'b0, 0, '0, '0, 1'b0, 1'b1);
    run_load(1'b0, 0, '0, '0, 1'b0, 1'b0);
    check_eq("frozen_gr9", gr_obs[9], 32'd0);

    // Rerun from FIN with a same-cycle table update of entry 0.
    run_load(1'b1, 0, 5'd1, 32'd9, 1'b1, 1'b0);
    check_eq("rerun_gr1", gr_obs[1], 32'd9);

    // Randomized tables and restarts.
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        cfg_write($urandom_range(0, N-1),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : ADDR_W'($urandom_range(1, 31)),
                  $urandom, 1'($urandom_range(0, 1)));
      end
      run_load(1'($urandom_range(0, 1)), $urandom_range(0, N-1),
               ADDR_W'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
    repeat (3) begin
      step();
      check_eq("hold_fin_done", done, 1'b1);
      check_eq("hold_fin_rf_we", rf_we, 1'b0);
    end

    // Second instance: auto-start, then a reset in the middle of a load.
    check_eq("b_rst_cpu_hold", b_cpu_hold, 1'b1);
    r_st_b = 1'b0;
    auto_empty_load();
    cfg_write(0, 5'd6, 32'h55, 1'b1);
    cfg_write(1, 5'd7, 32'h66, 1'b1);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check_eq("b_enter_busy", b_busy, 1'b1);
    step();
    check_eq("b_first_we", b_rf_we, 1'b1);
    check_eq("b_first_waddr", b_rf_waddr, 5'd6);
    #2 r_st_b = 1'b1;
    #1;
    check_eq("midrst_rf_we", b_rf_we, 1'b0);
    check_eq("midrst_cpu_hold", b_cpu_hold, 1'b1);
    check_eq("midrst_busy", b_busy, 1'b0);
    check_eq("midrst_done", b_done, 1'b0);
    check_eq("midrst_wdata", b_rf_wdata, 0);
    step();
    r_st_b = 1'b0;
    auto_empty_load();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
